// File: rtl/i281_step_ctrl.sv
// Step/run controller for the i281 CPU: debounced step and run buttons, a run-mode
// clock divider and a synchronized switch bank. Optional breakpoint halt: I281_BREAKPOINT_EN.
module i281_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_DIV         = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_step,
  input  logic        btn_run,
  input  logic [15:0] switches_in,
  input  logic [5:0]  current_pc,
  input  logic [5:0]  bp_addr,
  output logic        cpu_en,
  output logic [15:0] switches,
  output logic        running,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);
  localparam logic [15:0] DIV_PRE  = 16'(RUN_DIV - 2);

  // Bit 0 carries the step button, bit 1 the run button.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       level_q, level_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0][15:0] db_cnt_q, db_cnt_d;
  logic [15:0]      sw1_q, sw1_d;
  logic [15:0]      sw2_q, sw2_d;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic        resume_q, resume_d;
  logic        cpu_en_q, cpu_en_d;
  logic        running_q, running_d;
  logic        halted_q, halted_d;

  logic [1:0] press;
  logic       step_ev;
  logic       run_ev;

  always_comb begin
    sync1_d  = {btn_run, btn_step};
    sync2_d  = sync1_q;
    sw1_d    = switches_in;
    sw2_d    = sw1_q;
    prev_d   = level_q;
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    // The level flips on the last of DEBOUNCE_CYCLES consecutive disagreeing samples.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  assign press   = level_q & ~prev_q;
  assign step_ev = press[0];
  assign run_ev  = press[1];

  // cpu_en is decided one cycle early so the registered pulse lines up with div_q == RUN_DIV-1.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    resume_d = resume_q;
    cpu_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_ev) begin
          state_d = RUN;
          div_d   = '0;
        end else if (step_ev) begin
          cpu_en_d = 1'b1;
        end
      end
      RUN: begin
        if (run_ev) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
          if (div_q == DIV_PRE) begin
`ifdef I281_BREAKPOINT_EN
            resume_d = 1'b0;
            if ((current_pc == bp_addr) && !resume_q) begin
              state_d = HALT;
              div_d   = '0;
            end else begin
              cpu_en_d = 1'b1;
            end
`else
            cpu_en_d = 1'b1;
`endif
          end
        end
      end
      HALT: begin
`ifdef I281_BREAKPOINT_EN
        if (run_ev) begin
          state_d  = RUN;
          div_d    = '0;
          resume_d = 1'b1;
        end else if (step_ev) begin
          state_d  = IDLE;
          cpu_en_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
`ifdef I281_BREAKPOINT_EN
    halted_d = (state_d == HALT);
`else
    halted_d = 1'b0;
`endif
  end

`ifndef I281_BREAKPOINT_EN
  logic unused_bp;
  assign unused_bp = ^{bp_addr, current_pc};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      prev_q    <= '0;
      db_cnt_q  <= '0;
      sw1_q     <= '0;
      sw2_q     <= '0;
      state_q   <= IDLE;
      div_q     <= '0;
      resume_q  <= 1'b0;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      prev_q    <= prev_d;
      db_cnt_q  <= db_cnt_d;
      sw1_q     <= sw1_d;
      sw2_q     <= sw2_d;
      state_q   <= state_d;
      div_q     <= div_d;
      resume_q  <= resume_d;
      cpu_en_q  <= cpu_en_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign cpu_en   = cpu_en_q;
  assign switches = sw2_q;
  assign running  = running_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_i281_step_ctrl.sv
// Directed self-checking bench for i281_step_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=8).
// Breakpoint scenarios run only when I281_BREAKPOINT_EN is defined.
module tb_i281_step_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_run = 1'b0;
  logic [15:0] switches_in = 16'h0000;
  logic [5:0]  current_pc;
  logic [5:0]  bp_addr = 6'd5;
  logic        cpu_en;
  logic [15:0] switches;
  logic        running;
  logic        halted;

  int checkCount = 0;
  int errorCount = 0;

`ifdef I281_BREAKPOINT_EN
  localparam logic [5:0] PC_NORMAL = 6'd0;
`else
  localparam logic [5:0] PC_NORMAL = 6'd5;
`endif

  i281_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8)) dut (
    .clock(clock),
    .reset(reset),
    .btn_step(btn_step),
    .btn_run(btn_run),
    .switches_in(switches_in),
    .current_pc(current_pc),
    .bp_addr(bp_addr),
    .cpu_en(cpu_en),
    .switches(switches),
    .running(running),
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sample n cycles; count cpu_en pulses, first pulse index and back-to-back pulses.
  task automatic watchCpuEn(input int n, output int pulses, output int firstAt, output int doubles);
    logic last;
    last    = cpu_en;
    pulses  = 0;
    firstAt = 0;
    doubles = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (cpu_en) begin
        pulses++;
        if (firstAt == 0) firstAt = k;
        if (last) doubles++;
      end
      last = cpu_en;
    end
  endtask

  // which: 0 running, 1 halted, 2 cpu_en. waited = budget+1 on timeout.
  task automatic waitFor(input int which, input logic level, input int budget,
                         output int waited, output int pulses);
    logic sel;
    pulses = 0;
    waited = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (cpu_en) pulses++;
      case (which)
        0:       sel = running;
        1:       sel = halted;
        default: sel = cpu_en;
      endcase
      if (sel == level) begin
        waited = k;
        break;
      end
    end
  endtask

  task automatic applyStimulus();
    int p1, p2, first, dbl, waited, pulses, tmp;
    current_pc  = PC_NORMAL;
    switches_in = 16'hFFFF;
    waitCycles(3);
    checkOutput("rst_cpu_en", cpu_en, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_switches", switches, 16'h0000);
    switches_in = 16'h0000;
    reset = 1'b0;
    waitCycles(3);

    switches_in = 16'hA5C3;
    @(negedge clock);
    checkOutput("sw_lat1", switches, 16'h0000);
    @(negedge clock);
    checkOutput("sw_lat2", switches, 16'hA5C3);
    switches_in = 16'h5A3C;
    @(negedge clock);
    checkOutput("sw_hold", switches, 16'hA5C3);
    @(negedge clock);
    checkOutput("sw_next", switches, 16'h5A3C);

    btn_step = 1'b1;
    watchCpuEn(3, p1, tmp, dbl);
    btn_step = 1'b0;
    watchCpuEn(10, p2, tmp, dbl);
    checkOutput("glitch_pulses", p1 + p2, 0);

    btn_step = 1'b1;
    watchCpuEn(10, p1, first, dbl);
    btn_step = 1'b0;
    watchCpuEn(12, p2, tmp, dbl);
    checkOutput("step_pulses", p1 + p2, 1);
    checkOutput("step_latency", first, 7);
    checkOutput("step_running", running, 0);

    btn_run = 1'b1;
    waitFor(0, 1'b1, 20, waited, pulses);
    btn_run = 1'b0;
    checkOutput("run_latency", waited, 7);
    checkOutput("run_entry_pulses", pulses, 0);
    watchCpuEn(39, p1, first, dbl);
    checkOutput("run_pulses", p1, 5);
    checkOutput("run_first", first, 7);
    checkOutput("run_doubles", dbl, 0);
    checkOutput("run_still", running, 1);
`ifndef I281_BREAKPOINT_EN
    checkOutput("bp_ignored_halted", halted, 0);
`endif
    waitCycles(1);
    btn_run = 1'b1;
    waitFor(0, 1'b0, 20, waited, pulses);
    btn_run = 1'b0;
    checkOutput("stop_latency", waited, 7);
    checkOutput("stop_pulses", pulses, 0);
    watchCpuEn(20, p1, tmp, dbl);
    checkOutput("stop_after_pulses", p1, 0);
    checkOutput("stop_running", running, 0);

    btn_step = 1'b1;
    btn_run  = 1'b1;
    waitFor(0, 1'b1, 20, waited, pulses);
    btn_step = 1'b0;
    btn_run  = 1'b0;
    checkOutput("both_latency", waited, 7);
    checkOutput("both_pulses", pulses, 0);
    watchCpuEn(5, p1, tmp, dbl);
    checkOutput("both_no_step", p1, 0);
    checkOutput("both_running", running, 1);
    waitCycles(4);
    btn_run = 1'b1;
    waitFor(0, 1'b0, 20, waited, pulses);
    btn_run = 1'b0;
    checkOutput("both_stop", waited, 7);
    waitCycles(12);

`ifdef I281_BREAKPOINT_EN
    current_pc = 6'd5;
    btn_run = 1'b1;
    waitFor(0, 1'b1, 20, waited, pulses);
    btn_run = 1'b0;
    checkOutput("bp_run_latency", waited, 7);
    waitFor(1, 1'b1, 20, waited, pulses);
    checkOutput("bp_halt_at", waited, 7);
    checkOutput("bp_halt_pulses", pulses, 0);
    checkOutput("bp_halt_running", running, 0);
    btn_run = 1'b1;
    waitFor(0, 1'b1, 20, waited, pulses);
    btn_run = 1'b0;
    checkOutput("bp_resume_latency", waited, 7);
    checkOutput("bp_resume_halted", halted, 0);
    watchCpuEn(7, p1, first, dbl);
    checkOutput("bp_resume_pulses", p1, 1);
    checkOutput("bp_resume_first", first, 7);
    waitFor(1, 1'b1, 20, waited, pulses);
    checkOutput("bp_rehalt_at", waited, 8);
    checkOutput("bp_rehalt_pulses", pulses, 0);
    btn_step = 1'b1;
    watchCpuEn(10, p1, first, dbl);
    btn_step = 1'b0;
    checkOutput("bp_step_pulses", p1, 1);
    checkOutput("bp_step_first", first, 7);
    checkOutput("bp_step_halted", halted, 0);
    checkOutput("bp_step_running", running, 0);
    waitCycles(12);
    current_pc = PC_NORMAL;
`endif

    switches_in = 16'h1234;
    btn_run = 1'b1;
    waitFor(0, 1'b1, 20, waited, pulses);
    btn_run = 1'b0;
    checkOutput("rr_run_latency", waited, 7);
    waitFor(2, 1'b1, 20, waited, pulses);
    checkOutput("rr_tick_at", waited, 7);
    checkOutput("rr_switches_pre", switches, 16'h1234);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rr_running", running, 0);
    checkOutput("rr_cpu_en", cpu_en, 0);
    checkOutput("rr_switches", switches, 16'h0000);
    checkOutput("rr_halted", halted, 0);
    @(negedge clock);
    reset = 1'b0;
    watchCpuEn(20, p1, tmp, dbl);
    checkOutput("rr_idle_pulses", p1, 0);
    checkOutput("rr_idle_running", running, 0);
    checkOutput("rr_idle_halted", halted, 0);
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
